square_mag_int: RTL

SQUARE_MAG_INT -- requirements
Module: square_mag_int

---
 rtl/square_mag_int_if.sv | 35 +++
 rtl/square_mag_int.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/square_mag_int_if.sv
`default_nettype none
// ============================================================================
//  Module   : square_mag_int_if
//  Purpose  : Sample/result bundle for square_mag_int. The master side drives
//             complex FFT bins plus mode/clear controls; the slave side
//             returns the (optionally integrated) magnitude-squared stream.
//  Ports    : dv_fft, xk_re, xk_im, mode, clear   (master -> slave)
//             dv_sq_m, xk_sq_m, sat               (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface square_mag_int_if #(
  parameter int IN_W = 16
);
  localparam int OUT_W = 2 * IN_W;

  logic                    dv_fft;
  logic signed [IN_W-1:0]  xk_re;
  logic signed [IN_W-1:0]  xk_im;
  logic [1:0]              mode;
  logic                    clear;
  logic                    dv_sq_m;
  logic [OUT_W-1:0]        xk_sq_m;
  logic                    sat;

  modport master (
    output dv_fft, xk_re, xk_im, mode, clear,
    input  dv_sq_m, xk_sq_m, sat
  );

  modport slave (
    input  dv_fft, xk_re, xk_im, mode, clear,
    output dv_sq_m, xk_sq_m, sat
  );
endinterface
`default_nettype wire

// File: rtl/square_mag_int.sv
`default_nettype none
// ============================================================================
//  Module   : square_mag_int
//  Purpose  : Magnitude-squared of a complex sample stream with optional
//             integration over N = 2^AVG_LOG2 samples (bypass, mean or
//             saturating sum). Three-stage pipeline: input register,
//             squares, sum of squares.
//  Ports    : clock, reset (sync, active-high)
//             bus (square_mag_int_if.slave):
//               dv_fft/xk_re/xk_im/mode/clear in, dv_sq_m/xk_sq_m/sat out
//  Revision : 1.0 - initial release
// ============================================================================
module square_mag_int #(
  parameter int IN_W     = 16,
  parameter int AVG_LOG2 = 2
) (
  input wire logic        clock,
  input wire logic        reset,
  square_mag_int_if.slave bus
);
  localparam int OUT_W = 2 * IN_W;
  localparam int SQ_W  = 2 * IN_W - 1;
  localparam int ACC_W = OUT_W + AVG_LOG2;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_SUM    = 2'd2;

  // Pipeline valids and data. The mode travels with each sample so a block
  // is governed by the mode that was present when its first sample arrived.
  logic              v1, v2, v3;
  logic [IN_W-1:0]   re1, im1;
  logic [1:0]        m1, m2, m3;
  logic [SQ_W-1:0]   re_sq, im_sq;
  logic [OUT_W-1:0]  mag3;

  // Integration state and output registers
  logic [1:0]          blk_mode;
  logic [ACC_W-1:0]    acc;
  logic [AVG_LOG2-1:0] cnt;
  logic [OUT_W-1:0]    out_q;
  logic                int_dv;
  logic                sat_q;

  // Combinational helpers
  logic [SQ_W-1:0]     re_ext, im_ext;
  logic [SQ_W-1:0]     re_sq_w, im_sq_w;
  logic [1:0]          m3_norm;
  logic                blk_start;
  logic [1:0]          mode_eff;
  logic                integ;
  logic                last;
  logic                byp_emit;
  logic [AVG_LOG2-1:0] cnt_base;
  logic [ACC_W-1:0]    acc_sum;
  logic                ovf;
  logic [OUT_W-1:0]    mean_val;
  logic [OUT_W-1:0]    sum_val;

  // Squares are computed at SQ_W bits: the largest square, (-2^(IN_W-1))^2,
  // still fits, so modulo-2^SQ_W arithmetic on sign-extended operands is
  // exact.
  always_comb begin
    re_ext  = {{(SQ_W-IN_W){re1[IN_W-1]}}, re1};
    im_ext  = {{(SQ_W-IN_W){im1[IN_W-1]}}, im1};
    re_sq_w = re_ext * re_ext;
    im_sq_w = im_ext * im_ext;
  end

  always_comb begin
    m3_norm   = (m3 == 2'd3) ? MODE_BYPASS : m3;
    // A clear restarts the block, so a coinciding stage-3 sample opens it.
    blk_start = (cnt == '0) || bus.clear;
    mode_eff  = blk_start ? m3_norm : blk_mode;
    integ     = v3 && (mode_eff != MODE_BYPASS);
    last      = integ && !bus.clear && (&cnt);
    // A block result leaving in the same cycle takes the output slot; a
    // colliding bypass word is dropped.
    byp_emit  = v3 && (mode_eff == MODE_BYPASS) && !bus.clear && !int_dv;
    cnt_base  = bus.clear ? '0 : cnt;
    acc_sum   = (bus.clear ? '0 : acc) + {{AVG_LOG2{1'b0}}, mag3};
    ovf       = |acc_sum[ACC_W-1:OUT_W];
    mean_val  = acc_sum[ACC_W-1:AVG_LOG2];
    sum_val   = ovf ? {OUT_W{1'b1}} : acc_sum[OUT_W-1:0];
  end

  // Datapath registers carry no reset: they are qualified by the valids.
  always_ff @(posedge clock) begin
    re1   <= bus.xk_re;
    im1   <= bus.xk_im;
    m1    <= bus.mode;
    m2    <= m1;
    m3    <= m2;
    re_sq <= re_sq_w;
    im_sq <= im_sq_w;
    mag3  <= {1'b0, re_sq} + {1'b0, im_sq};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      blk_mode <= MODE_BYPASS;
      acc      <= '0;
      cnt      <= '0;
      out_q    <= '0;
      int_dv   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      // clear kills samples already in flight but admits the one arriving now
      v1     <= bus.dv_fft;
      v2     <= v1 && !bus.clear;
      v3     <= v2 && !bus.clear;
      int_dv <= 1'b0;

      if (v3 && blk_start) begin
        blk_mode <= m3_norm;
      end

      if (last) begin
        acc    <= '0;
        cnt    <= '0;
        int_dv <= 1'b1;
        out_q  <= (blk_mode == MODE_SUM) ? sum_val : mean_val;
        if ((blk_mode == MODE_SUM) && ovf) begin
          sat_q <= 1'b1;
        end
      end else if (integ) begin
        acc <= acc_sum;
        cnt <= cnt_base + AVG_LOG2'(1);
      end else if (bus.clear) begin
        acc <= '0;
        cnt <= '0;
      end

      if (byp_emit) begin
        out_q <= mag3;
      end
    end
  end

  // Bypass words leave straight from stage 3 to meet the 3-cycle latency;
  // block results come from the output register one cycle later.
  assign bus.dv_sq_m = int_dv ? !bus.clear : byp_emit;
  assign bus.xk_sq_m = byp_emit ? mag3 : out_q;
  assign bus.sat     = sat_q;

endmodule
`default_nettype wire
